// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-latency arbiter between instruction fetch (I) and
// load/store (D) for a single-port unified memory. One transaction in
// flight, round-robin on conflicts, response timed by an internal counter.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       last_d, last_d_nxt;
  logic       store_q, store_nxt;   // outstanding D transaction is a store
  logic       resp, issue, gnt_i, gnt_d;

  // State, latency counter, round-robin pointer and store flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      cnt     <= '0;
      last_d  <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last_d  <= last_d_nxt;
      store_q <= store_nxt;
    end
  end

  // Arbitration, next-state and all outputs; every output is forced low
  // while nrst is held, including paths from the request inputs.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_d_nxt = last_d;
    store_nxt  = store_q;
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    stall      = 1'b0;

    resp  = (state != IDLE) && (cnt == '0);
    issue = (state == IDLE) || (cnt == '0);

    if (nrst && issue) begin
      if (d_req && (!i_req || !last_d)) gnt_d = 1'b1;
      else if (i_req)                   gnt_i = 1'b1;
    end

    if (gnt_d) begin
      state_nxt  = BUSY_D;
      cnt_nxt    = LAT_M1;
      last_d_nxt = 1'b1;
      store_nxt  = d_we;
      d_gnt      = 1'b1;
      mem_en     = 1'b1;
      mem_we     = d_we;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
    end else if (gnt_i) begin
      state_nxt  = BUSY_I;
      cnt_nxt    = LAT_M1;
      last_d_nxt = 1'b0;
      store_nxt  = 1'b0;
      i_gnt      = 1'b1;
      mem_en     = 1'b1;
      mem_addr   = i_addr;
    end else if (resp) begin
      state_nxt  = IDLE;
    end else if (state != IDLE) begin
      cnt_nxt    = cnt - 4'd1;
    end

    if (resp && state == BUSY_I) begin
      i_rvalid = 1'b1;
      i_rdata  = mem_rdata;
    end
    if (resp && state == BUSY_D) begin
      d_rvalid = 1'b1;
      d_rdata  = store_q ? '0 : mem_rdata;
    end

    stall = nrst && ((i_req && !gnt_i) || (d_req && !gnt_d) ||
                     ((state != IDLE) && !resp));
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests of mem_arbiter at MEM_LAT=4 and MEM_LAT=1.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] mem_rdata = 32'h1234_5678;

  // MEM_LAT = 4 instance
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  // MEM_LAT = 1 instance
  logic        l1_i_req = 1'b0, l1_d_req = 1'b0, l1_d_we = 1'b0;
  logic [31:0] l1_i_addr = '0, l1_d_addr = '0, l1_d_wdata = '0;
  logic        l1_i_gnt, l1_i_rvalid, l1_d_gnt, l1_d_rvalid, l1_mem_en, l1_mem_we, l1_stall;
  logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .nrst(nrst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .nrst(nrst),
    .i_req(l1_i_req), .i_addr(l1_i_addr), .i_gnt(l1_i_gnt), .i_rvalid(l1_i_rvalid), .i_rdata(l1_i_rdata),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(mem_rdata), .stall(l1_stall)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with idle inputs, release in cycle 0.
  task automatic apply_reset();
    nrst = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    l1_d_req = 1'b0; l1_d_addr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    nrst = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h30;
    #2;
    flags = {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid, stall};
    n_cmp++; if (flags !== 7'b0) begin n_err++; $display("FAIL reset_flags got=%b exp=0", flags); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    apply_reset();
    #1;
    n_cmp++; if ({i_gnt, d_gnt, stall, mem_en} !== 4'b0) begin n_err++; $display("FAIL reset_idle got=%b exp=0", {i_gnt, d_gnt, stall, mem_en}); end
  endtask

  task automatic test_single_fetch();
    apply_reset();
    step(); step();                       // now cycle 2
    i_req = 1'b1; i_addr = 32'h100;
    #1;
    n_cmp++; if ({i_gnt, mem_en, mem_we, d_gnt} !== 4'b1100) begin n_err++; $display("FAIL fetch_gnt got=%b exp=1100", {i_gnt, mem_en, mem_we, d_gnt}); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL fetch_addr got=%h exp=100", mem_addr); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_c2 got=%b exp=0", stall); end
    step(); i_req = 1'b0; i_addr = '0;
    for (int k = 3; k <= 5; k++) begin
      #1;
      n_cmp++; if ({stall, i_rvalid, mem_en} !== 3'b100) begin n_err++; $display("FAIL fetch_wait_c%0d got=%b exp=100", k, {stall, i_rvalid, mem_en}); end
      step();
    end
    #1;                                   // cycle 6
    n_cmp++; if ({i_rvalid, stall} !== 2'b10) begin n_err++; $display("FAIL fetch_resp got=%b exp=10", {i_rvalid, stall}); end
    n_cmp++; if (i_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL fetch_rdata got=%h exp=12345678", i_rdata); end
    step(); #1;                           // cycle 7
    n_cmp++; if ({i_rvalid, stall} !== 2'b00 || i_rdata !== 32'h0) begin n_err++; $display("FAIL fetch_after got=%b/%h exp=00/0", {i_rvalid, stall}, i_rdata); end
  endtask

  task automatic test_store_load();
    apply_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if ({d_gnt, mem_en, mem_we} !== 3'b111) begin n_err++; $display("FAIL store_gnt got=%b exp=111", {d_gnt, mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_bus got=%h/%h exp=200/deadbeef", mem_addr, mem_wdata); end
    step(); d_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_cmp++; if ({mem_en, mem_we, d_rvalid} !== 3'b000 || mem_wdata !== 32'h0) begin n_err++; $display("FAIL store_wait_c%0d got=%b/%h exp=000/0", k, {mem_en, mem_we, d_rvalid}, mem_wdata); end
      step();
    end
    // cycle 4: store completes while a load is issued back to back
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h5555_5555;
    #1;
    n_cmp++; if ({d_rvalid, d_gnt, mem_we, stall} !== 4'b1100) begin n_err++; $display("FAIL store_resp got=%b exp=1100", {d_rvalid, d_gnt, mem_we, stall}); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_err++; $display("FAIL store_rdata got=%h exp=0", d_rdata); end
    n_cmp++; if (mem_addr !== 32'h300) begin n_err++; $display("FAIL load_addr got=%h exp=300", mem_addr); end
    step(); d_req = 1'b0;
    step(); step(); step(); #1;           // cycle 8
    n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL load_resp got=%b/%h exp=1/12345678", d_rvalid, d_rdata); end
  endtask

  task automatic test_contention();
    logic exp_dg, exp_ig, exp_iv, exp_dv;
    logic [31:0] exp_addr;
    apply_reset();
    i_req = 1'b1; i_addr = 32'h900;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp_dg = (k % 8 == 0);
      exp_ig = (k % 8 == 4);
      exp_iv = (k % 8 == 0) && (k > 0);
      exp_dv = (k % 8 == 4);
      exp_addr = exp_dg ? 32'h800 : (exp_ig ? 32'h900 : 32'h0);
      n_cmp++; if ({d_gnt, i_gnt} !== {exp_dg, exp_ig}) begin n_err++; $display("FAIL rr_gnt_c%0d got=%b exp=%b", k, {d_gnt, i_gnt}, {exp_dg, exp_ig}); end
      n_cmp++; if ({d_rvalid, i_rvalid} !== {exp_dv, exp_iv}) begin n_err++; $display("FAIL rr_rvalid_c%0d got=%b exp=%b", k, {d_rvalid, i_rvalid}, {exp_dv, exp_iv}); end
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rr_stall_c%0d got=%b exp=1", k, stall); end
      n_cmp++; if (mem_addr !== exp_addr) begin n_err++; $display("FAIL rr_addr_c%0d got=%h exp=%h", k, mem_addr, exp_addr); end
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_g, exp_v, exp_s;
    apply_reset();
    i_req = 1'b1; i_addr = 32'h40;
    for (int k = 0; k <= 12; k++) begin
      #1;
      exp_g = (k % 4 == 0);
      exp_v = (k % 4 == 0) && (k > 0);
      exp_s = (k % 4 != 0);
      n_cmp++; if ({i_gnt, i_rvalid, stall} !== {exp_g, exp_v, exp_s}) begin n_err++; $display("FAIL b2b_c%0d got=%b exp=%b", k, {i_gnt, i_rvalid, stall}, {exp_g, exp_v, exp_s}); end
      step();
    end
    i_req = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [6:0] flags;
    apply_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    #1;
    n_cmp++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL mid_load_gnt got=%b exp=1", d_gnt); end
    step(); d_req = 1'b0;
    step();                               // cycle 2 of the load
    i_req = 1'b1; i_addr = 32'h500;
    nrst = 1'b0;
    #1;
    flags = {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid, stall};
    n_cmp++; if (flags !== 7'b0 || mem_addr !== 32'h0) begin n_err++; $display("FAIL mid_reset_out got=%b/%h exp=0/0", flags, mem_addr); end
    step();
    nrst = 1'b1;                          // first cycle after release
    #1;
    n_cmp++; if ({i_gnt, d_rvalid} !== 2'b10 || mem_addr !== 32'h500) begin n_err++; $display("FAIL mid_post_gnt got=%b/%h exp=10/500", {i_gnt, d_rvalid}, mem_addr); end
    step(); i_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      n_cmp++; if (d_rvalid !== 1'b0 || i_rvalid !== (k == 4)) begin n_err++; $display("FAIL mid_post_c%0d got=%b%b exp=0%b", k, d_rvalid, i_rvalid, (k == 4)); end
      step();
    end
  endtask

  task automatic test_lat1();
    apply_reset();
    l1_d_req = 1'b1; l1_d_addr = 32'h600;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if ({l1_d_gnt, l1_d_rvalid, l1_stall} !== {1'b1, (k > 0), 1'b0}) begin n_err++; $display("FAIL lat1_c%0d got=%b exp=1%b0", k, {l1_d_gnt, l1_d_rvalid, l1_stall}, (k > 0)); end
      n_cmp++; if (l1_d_rdata !== ((k > 0) ? 32'h1234_5678 : 32'h0)) begin n_err++; $display("FAIL lat1_rdata_c%0d got=%h", k, l1_d_rdata); end
      step();
    end
    l1_d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_back_to_back();
    test_reset_midflight();
    test_lat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
